sha_padder: RTL and testbench
=============================

SHA_PADDER -- requirements
Module: sha_padder

Interface
REQ-001 SHALL have ports: clk  input  1  rising-edge clock for all state.
REQ-002 SHALL have ports: rst  input  1  asynchronous active-high reset.
REQ-003 SHALL have ports: in_valid  input  1  message byte present.
REQ-004 SHALL have ports: in_byte  input  8  message byte.
REQ-005 SHALL have ports: in_last  input  1  qualifies in_byte as final byte of message.
REQ-006 SHALL have ports: in_flush  input  1  ends a message with no byte this cycle; used for empty messages and for ending after a byte sent without in_last.
REQ-007 SHALL have ports: in_ready  output  1  byte/flush accepted when high with in_valid or in_flush.
REQ-008 SHALL have ports: blk_valid  output  1  padded block available.
REQ-009 SHALL have ports: blk_ready  input  1  downstream consumes block.
REQ-010 SHALL have ports: blk_word  output  32 x 16 unpacked array  block words W[0..15], big-endian.
REQ-011 SHALL have ports: blk_last  output  1  block is final block of message.

Function
REQ-012 SHALL pack bytes big-endian: byte position p goes to blk_word[p/4][31-8*(p%4) -: 8].
REQ-013 SHALL use states ABSORB, PAD, EXTRA, EMIT; reset state ABSORB.
REQ-014 ABSORB: in_ready=1; in_valid accepted in a cycle stores the byte at position p, increments p and the 61-bit message byte counter.
REQ-015 ABSORB: p reaching 64 without in_last SHALL go to EMIT with blk_last=0, then return to ABSORB with p=0.
REQ-016 ABSORB: accepted in_last byte or in_flush SHALL go to PAD next cycle; in_valid with in_last and in_flush together is treated as in_last only.
REQ-017 ABSORB: a 64th byte with in_last SHALL emit the data block (blk_last=0), then enter PAD with p=0.
REQ-018 PAD (one cycle): byte p=0x80, bytes p+1..63 = 0x00; if p<=55, bytes 56..63 = bit length (counter*8, 64-bit big-endian) and go to EMIT with blk_last=1; else go to EMIT with blk_last=0 and flag EXTRA.
REQ-019 EXTRA (one cycle): bytes 0..55 = 0x00, bytes 56..63 = bit length; go to EMIT with blk_last=1.
REQ-020 EMIT: blk_valid=1, in_ready=0; blk_word/blk_last SHALL be held stable until blk_valid&&blk_ready; handshake cycle advances to EXTRA (if flagged) or ABSORB.
REQ-021 After a final block is handshaken: byte counter and p SHALL clear to 0.
REQ-022 Latency: last byte accepted in cycle T -> blk_valid high in cycle T+2 (single-block case).
REQ-023 The byte counter SHALL wrap modulo 2^61; the length field is always counter*8 truncated to 64 bits.
REQ-024 in_ready SHALL be 0 in PAD, EXTRA, EMIT; inputs there are ignored.

Reset
REQ-025 On rst: state=ABSORB, p=0, counter=0, all blk_word=0, blk_valid=0, blk_last=0, in_ready=1 once rst deasserts.
REQ-026 Reset asserted mid-block or during EMIT SHALL discard the partial message immediately; no block is emitted.

Configuration
REQ-027 Macro SHA_PADDER_LEN_OUT_EN: when defined, adds output msg_bits (64) equal to the length field of the current final block, valid while blk_valid&&blk_last, reset 0.
REQ-028 Without SHA_PADDER_LEN_OUT_EN the port is absent; all other behaviour is identical.

Verification
REQ-029 "abc" (0x61,0x62,0x63 with in_last on 0x63) -> one block, W[0]=0x61626380, W[1..14]=0, W[15]=0x00000018, blk_last=1, blk_valid at T+2.
REQ-030 in_flush with no bytes -> one block, W[0]=0x80000000, W[1..15]=0, blk_last=1.
REQ-031 56 bytes 0x00, last on 56th -> block 1 W[14]=0x80000000, W[15]=0, blk_last=0; block 2 W[0..14]=0, W[15]=0x000001C0, blk_last=1.
REQ-032 64 bytes 0xFF, last on 64th -> block 1 all 0xFFFFFFFF, blk_last=0; block 2 W[0]=0x80000000, W[15]=0x00000200, blk_last=1.
REQ-033 Hold blk_ready=0 for 10 cycles during EMIT -> blk_valid stays 1, blk_word stable, in_ready=0; release -> one handshake only.
REQ-034 Assert rst after 30 bytes of a message -> outputs return to reset values; subsequent "abc" yields the block of REQ-029.

Source files
------------

// File: rtl/sha_padder.sv
`default_nettype none
// ============================================================================
// Module   : sha_padder
// Brief    : SHA-1/SHA-256 message padder. Packs a byte stream into 512-bit
//            big-endian blocks and appends the 0x80 marker and 64-bit length.
//            Optional macro SHA_PADDER_LEN_OUT_EN adds the msg_bits output.
// Revision : 1.0 - initial release
// ============================================================================
module sha_padder (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [7:0]  in_byte,
  input  logic        in_last,
  input  logic        in_flush,
  output logic        in_ready,
  output logic        blk_valid,
  input  logic        blk_ready,
  output logic [31:0] blk_word [16],
  output logic        blk_last
`ifdef SHA_PADDER_LEN_OUT_EN
  ,
  output logic [63:0] msg_bits
`endif
);

  typedef enum logic [1:0] {
    ABSORB = 2'd0,
    PAD    = 2'd1,
    EXTRA  = 2'd2,
    EMIT   = 2'd3
  } state_t;

  state_t      r_state;
  logic [5:0]  r_p;
  logic [60:0] r_cnt;
  logic [7:0]  r_buf [64];
  logic        r_extra;
  logic        r_pad_next;
  logic        r_blk_valid;
  logic        r_blk_last;
  logic        r_in_ready;

  logic [63:0] w_len;
  logic [7:0]  w_pad   [64];
  logic [7:0]  w_extra [64];
  logic        w_end;

  // Counter is 61 bits so the shifted bit length is exactly 64 bits wide.
  assign w_len = {r_cnt, 3'b000};
  assign w_end = in_last | in_flush;

  always_comb begin
    for (int i = 0; i < 64; i++) begin
      if (6'(i) < r_p)
        w_pad[i] = r_buf[i];
      else if (6'(i) == r_p)
        w_pad[i] = 8'h80;
      else
        w_pad[i] = 8'h00;
    end
    if (r_p <= 6'd55) begin
      for (int i = 56; i < 64; i++)
        w_pad[i] = w_len[8*(63-i) +: 8];
    end
  end

  always_comb begin
    for (int i = 0; i < 56; i++)
      w_extra[i] = 8'h00;
    for (int i = 56; i < 64; i++)
      w_extra[i] = w_len[8*(63-i) +: 8];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ABSORB;
      r_p         <= '0;
      r_cnt       <= '0;
      r_extra     <= 1'b0;
      r_pad_next  <= 1'b0;
      r_blk_valid <= 1'b0;
      r_blk_last  <= 1'b0;
      r_in_ready  <= 1'b1;
      for (int i = 0; i < 64; i++)
        r_buf[i] <= '0;
    end else begin
      case (r_state)
        ABSORB: begin
          if (in_valid) begin
            r_buf[r_p] <= in_byte;
            r_cnt      <= r_cnt + 61'd1;
            if (r_p == 6'd63) begin
              // Full data block: ship it first, pad afterwards if it was the last byte.
              r_p         <= '0;
              r_pad_next  <= w_end;
              r_blk_last  <= 1'b0;
              r_blk_valid <= 1'b1;
              r_in_ready  <= 1'b0;
              r_state     <= EMIT;
            end else begin
              r_p <= r_p + 6'd1;
              if (w_end) begin
                r_in_ready <= 1'b0;
                r_state    <= PAD;
              end
            end
          end else if (in_flush) begin
            r_in_ready <= 1'b0;
            r_state    <= PAD;
          end
        end

        PAD: begin
          r_buf       <= w_pad;
          r_blk_valid <= 1'b1;
          r_state     <= EMIT;
          if (r_p <= 6'd55) begin
            r_blk_last <= 1'b1;
          end else begin
            r_blk_last <= 1'b0;
            r_extra    <= 1'b1;
          end
        end

        EXTRA: begin
          r_buf       <= w_extra;
          r_blk_valid <= 1'b1;
          r_blk_last  <= 1'b1;
          r_state     <= EMIT;
        end

        EMIT: begin
          if (blk_ready) begin
            r_blk_valid <= 1'b0;
            if (r_extra) begin
              r_extra <= 1'b0;
              r_state <= EXTRA;
            end else if (r_pad_next) begin
              r_pad_next <= 1'b0;
              r_state    <= PAD;
            end else begin
              r_in_ready <= 1'b1;
              r_state    <= ABSORB;
            end
            if (r_blk_last) begin
              r_cnt      <= '0;
              r_p        <= '0;
              r_blk_last <= 1'b0;
            end
          end
        end

        default: r_state <= ABSORB;
      endcase
    end
  end

  for (genvar g = 0; g < 16; g++) begin : g_pack
    assign blk_word[g] = {r_buf[4*g], r_buf[4*g+1], r_buf[4*g+2], r_buf[4*g+3]};
  end

  assign in_ready  = r_in_ready;
  assign blk_valid = r_blk_valid;
  assign blk_last  = r_blk_last;

`ifdef SHA_PADDER_LEN_OUT_EN
  logic [63:0] r_msg_bits;

  // Captured whenever a final block is built; the counter is stable until its handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_msg_bits <= '0;
    else if ((r_state == PAD && r_p <= 6'd55) || r_state == EXTRA)
      r_msg_bits <= w_len;
  end

  assign msg_bits = r_msg_bits;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sha_padder.sv
`default_nettype none
// ============================================================================
// Module   : tb_sha_padder
// Brief    : Self-checking bench for sha_padder; a reference padding model
//            fills a block scoreboard that the output monitor drains.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sha_padder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [7:0]  in_byte = 8'h00;
  logic        in_last = 1'b0;
  logic        in_flush = 1'b0;
  logic        in_ready;
  logic        blk_valid;
  logic        blk_ready = 1'b1;
  logic [31:0] blk_word [16];
  logic        blk_last;
`ifdef SHA_PADDER_LEN_OUT_EN
  logic [63:0] msg_bits;
`endif

  sha_padder dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_byte   (in_byte),
    .in_last   (in_last),
    .in_flush  (in_flush),
    .in_ready  (in_ready),
    .blk_valid (blk_valid),
    .blk_ready (blk_ready),
    .blk_word  (blk_word),
    .blk_last  (blk_last)
`ifdef SHA_PADDER_LEN_OUT_EN
    ,
    .msg_bits  (msg_bits)
`endif
  );

  always #5 clk = ~clk;

  typedef logic [7:0] bq_t [$];
  typedef struct packed {
    logic [511:0] d;
    logic         last;
  } blk_t;

  blk_t         sb [$];
  blk_t         exp_blk;
  int           total = 0;
  int           bad = 0;
  int           cyc = 0;
  int           n_hs = 0;
  logic [511:0] prev_blk;
  logic         held = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [511:0] cur_blk();
    logic [511:0] r;
    for (int w = 0; w < 16; w++) r[511-32*w -: 32] = blk_word[w];
    return r;
  endfunction

  // Reference: standard SHA padding of the whole message, then cut into 64-byte blocks.
  task automatic push_expected(input bq_t msg);
    bq_t          s;
    logic [63:0]  len;
    blk_t         b;
    int           nblk;
    s = msg;
    len = 64'(msg.size()) * 64'd8;
    s.push_back(8'h80);
    while (s.size() % 64 != 56) s.push_back(8'h00);
    for (int k = 7; k >= 0; k--) s.push_back(len[8*k +: 8]);
    nblk = s.size() / 64;
    for (int j = 0; j < nblk; j++) begin
      for (int i = 0; i < 64; i++) b.d[511-8*i -: 8] = s[64*j+i];
      b.last = (j == nblk - 1);
      sb.push_back(b);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      held = 1'b0;
    end else begin
      if (held) begin
        check("hold_valid", 512'(blk_valid), 512'd1);
        check("hold_word", cur_blk(), prev_blk);
      end
      if (blk_valid && blk_ready) begin
        n_hs++;
        if (sb.size() == 0) begin
          check("unexpected_blk", 512'd1, 512'd0);
        end else begin
          exp_blk = sb.pop_front();
          check("blk_data", cur_blk(), exp_blk.d);
          check("blk_last", 512'(blk_last), 512'(exp_blk.last));
        end
      end
      held = blk_valid && !blk_ready;
      prev_blk = cur_blk();
    end
  end

  task automatic wait_ready();
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("in_ready_timeout", 512'd0, 512'd1);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic last);
    wait_ready();
    in_valid = 1'b1;
    in_byte  = b;
    in_last  = last;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send_flush();
    wait_ready();
    in_flush = 1'b1;
    @(posedge clk);
    #1;
    in_flush = 1'b0;
  endtask

  task automatic send_msg(input bq_t m, input logic by_flush);
    push_expected(m);
    for (int i = 0; i < m.size(); i++)
      send_byte(m[i], !by_flush && (i == m.size() - 1));
    if (by_flush || m.size() == 0) send_flush();
  endtask

  task automatic wait_blk_valid(input string tag);
    int n = 0;
    @(negedge clk);
    while (!blk_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!blk_valid) check(tag, 512'd0, 512'd1);
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("drain", 512'(sb.size()), 512'd0);
  endtask

  initial begin
    bq_t m;
    int  acc;
    int  h0;

    repeat (3) @(negedge clk);
    check("rst_valid", 512'(blk_valid), 512'd0);
    check("rst_last", 512'(blk_last), 512'd0);
    check("rst_words", cur_blk(), 512'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", 512'(in_ready), 512'd1);

    // "abc" with latency measurement: accepted in the cycle ending at edge acc.
    m = '{8'h61, 8'h62, 8'h63};
    push_expected(m);
    send_byte(8'h61, 1'b0);
    send_byte(8'h62, 1'b0);
    send_byte(8'h63, 1'b1);
    acc = cyc;
    wait_blk_valid("abc_timeout");
    check("abc_latency", 512'(cyc - acc), 512'd1);
    check("abc_w0", 512'(blk_word[0]), 512'h61626380);
    check("abc_w15", 512'(blk_word[15]), 512'h00000018);
    check("abc_last", 512'(blk_last), 512'd1);
    drain();

    // Empty message via flush.
    m.delete();
    push_expected(m);
    send_flush();
    wait_blk_valid("empty_timeout");
    check("empty_w0", 512'(blk_word[0]), 512'h80000000);
    drain();

    m.delete();
    for (int i = 0; i < 56; i++) m.push_back(8'h00);
    send_msg(m, 1'b0);
    drain();

    m.delete();
    for (int i = 0; i < 64; i++) m.push_back(8'hFF);
    send_msg(m, 1'b0);
    drain();

    m.delete();
    for (int i = 0; i < 55; i++) m.push_back(8'($urandom));
    send_msg(m, 1'b0);
    drain();

    m.delete();
    for (int i = 0; i < 10; i++) m.push_back(8'($urandom));
    send_msg(m, 1'b1);
    drain();

    m.delete();
    for (int i = 0; i < 119; i++) m.push_back(8'($urandom));
    send_msg(m, 1'b0);
    m.delete();
    for (int i = 0; i < 130; i++) m.push_back(8'($urandom));
    send_msg(m, 1'b0);
    drain();

    // Back-pressure: block held for 10 cycles, then exactly one handshake.
    blk_ready = 1'b0;
    m = '{8'h61, 8'h62, 8'h63};
    send_msg(m, 1'b0);
    wait_blk_valid("stall_timeout");
    h0 = n_hs;
    repeat (10) begin
      @(negedge clk);
      check("stall_valid", 512'(blk_valid), 512'd1);
      check("stall_in_ready", 512'(in_ready), 512'd0);
    end
    @(posedge clk);
    #1 blk_ready = 1'b1;
    repeat (5) @(negedge clk);
    check("stall_handshakes", 512'(n_hs - h0), 512'd1);
    drain();

    // Reset in the middle of a message discards it.
    for (int i = 0; i < 30; i++) send_byte(8'(i + 1), 1'b0);
    #2 rst = 1'b1;
    @(negedge clk);
    check("midrst_valid", 512'(blk_valid), 512'd0);
    check("midrst_last", 512'(blk_last), 512'd0);
    check("midrst_words", cur_blk(), 512'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("midrst_in_ready", 512'(in_ready), 512'd1);
    m = '{8'h61, 8'h62, 8'h63};
    send_msg(m, 1'b0);
    wait_blk_valid("postrst_timeout");
    check("postrst_w0", 512'(blk_word[0]), 512'h61626380);
    check("postrst_w15", 512'(blk_word[15]), 512'h00000018);
    drain();

    repeat (5) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
